// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, one-entry skid
// buffer, redirect flush with in-flight response drop, and sticky halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, DROP, HALTED} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] slot_q, slot_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic        valid_q, valid_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic ack_fire, consume, take_halt, launch;

  assign ack_fire  = req_q & imem_ack;
  assign consume   = valid_q & ~stall;
  assign take_halt = (state_q == FETCH) & consume & halt;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (take_halt)                           state_d = HALTED;
        else if (redirect && req_q && !ack_fire) state_d = DROP;
      end
      DROP:    if (ack_fire) state_d = FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  // pc_q is the address of the next request to launch; on an accepted ack it
  // advances so a back-to-back launch uses the already-incremented value.
  always_comb begin
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    slot_d    = slot_q;
    slot_pc_d = slot_pc_q;
    valid_d   = valid_q;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    launch    = 1'b0;
    if (state_q == HALTED || take_halt) begin
      valid_d  = 1'b0;
      skid_v_d = 1'b0;
      if (ack_fire) req_d = 1'b0;
    end else if (redirect) begin
      valid_d  = 1'b0;
      skid_v_d = 1'b0;
      pc_d     = redirect_pc & ~32'h3;
      launch   = (state_d != DROP);
    end else if (state_q == DROP) begin
      launch = ack_fire;
    end else begin
      if (ack_fire) pc_d = pc_q + 32'd4;
      if (consume && skid_v_q) begin
        slot_d    = skid_q;
        slot_pc_d = skid_pc_q;
        skid_v_d  = 1'b0;
        if (ack_fire) begin
          skid_d    = imem_rdata;
          skid_pc_d = addr_q;
          skid_v_d  = 1'b1;
        end
      end else if (ack_fire && (!valid_q || consume)) begin
        slot_d    = imem_rdata;
        slot_pc_d = addr_q;
        valid_d   = 1'b1;
      end else if (ack_fire) begin
        skid_d    = imem_rdata;
        skid_pc_d = addr_q;
        skid_v_d  = 1'b1;
      end else if (consume) begin
        valid_d = 1'b0;
      end
      launch = (!req_q || ack_fire) && !skid_v_d;
      if (ack_fire && !launch) req_d = 1'b0;
    end
    if (launch) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      slot_q    <= NOP_INSTR;
      slot_pc_q <= '0;
      valid_q   <= 1'b0;
      skid_v_q  <= 1'b0;
      skid_q    <= '0;
      skid_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      slot_q    <= slot_d;
      slot_pc_q <= slot_pc_d;
      valid_q   <= valid_d;
      skid_v_q  <= skid_v_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
    end
  end

  always_comb begin
    imem_req    = req_q;
    imem_addr   = addr_q;
    instr       = valid_q ? slot_q : NOP_INSTR;
    instr_pc    = slot_pc_q;
    instr_valid = valid_q;
    halted      = (state_q == HALTED);
  end

endmodule
